// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32 main-control FSM.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REGA  = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational decode of FSM state into datapath control; enables are qualified by en.
module mc_output_decode
    import riscv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       en,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCWrite,
    output logic       PCSource,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       MemtoReg
);

    logic pcwrite_d, irwrite_d, memread_d, memwrite_d, regwrite_d;

    always_comb begin
        ALUOp      = ALUOP_ADD;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REGB;
        PCSource   = PCSRC_ALU;
        IorD       = 1'b0;
        MemtoReg   = 1'b0;
        pcwrite_d  = 1'b0;
        irwrite_d  = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        regwrite_d = 1'b0;
        case (state)
            FETCH: begin
                memread_d = 1'b1;
                // The instruction word and PC+4 land in the same cycle the fetch completes.
                if (mem_ready) begin
                    irwrite_d = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    pcwrite_d = 1'b1;
                end
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                memread_d = 1'b1;
                IorD      = 1'b1;
            end
            MEMWB: begin
                regwrite_d = 1'b1;
                MemtoReg   = 1'b1;
            end
            MEMWR: begin
                memwrite_d = 1'b1;
                IorD       = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = SRCA_REGA;
                ALUOp   = ALUOP_FUNC;
            end
            ALUWB: regwrite_d = 1'b1;
            BRANCH: begin
                ALUSrcA   = SRCA_REGA;
                ALUOp     = ALUOP_SUB;
                PCSource  = PCSRC_ALUOUT;
                pcwrite_d = zero;
            end
            default: ;
        endcase
    end

    assign PCWrite  = pcwrite_d  & en;
    assign IRWrite  = irwrite_d  & en;
    assign MemRead  = memread_d  & en;
    assign MemWrite = memwrite_d & en;
    assign RegWrite = regwrite_d & en;

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle RV32 main-control FSM: instruction sequencing, memory wait/timeout and retire count.
module multicycle_main_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             PCWrite,
    output logic             PCSource,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             illegal_instr,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           mem_state, timeout_hit, retire, illegal_set;

    assign mem_state   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign timeout_hit = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        illegal_set = 1'b0;
        case (state)
            FETCH: if (mem_ready) state_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_R:              state_nxt = EXEC_R;
                    OP_BRANCH:         state_nxt = BRANCH;
                    default: begin
                        state_nxt   = FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            MEMADR: state_nxt = (opcode == OP_LOAD) ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_ready)        state_nxt = MEMWB;
                else if (timeout_hit) state_nxt = FETCH;
            end
            MEMWR: begin
                if (mem_ready) begin
                    state_nxt = FETCH;
                    retire    = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = FETCH;
                end
            end
            MEMWB, ALUWB, BRANCH: begin
                state_nxt = FETCH;
                retire    = 1'b1;
            end
            EXEC_R:  state_nxt = ALUWB;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            wait_cnt      <= '0;
            retired       <= '0;
            illegal_instr <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counter is zero whenever a memory state is entered because every non-waiting cycle clears it.
            if (mem_state && !mem_ready && !timeout_hit) wait_cnt <= wait_cnt + WCW'(1);
            else                                         wait_cnt <= '0;
            if (retire)      retired       <= retired + CNT_W'(1);
            if (illegal_set) illegal_instr <= 1'b1;
            if (timeout_hit) mem_timeout   <= 1'b1;
        end
    end

    mc_output_decode u_decode (
        .state     (state),
        .zero      (zero),
        .mem_ready (mem_ready),
        .en        (!reset),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .PCWrite   (PCWrite),
        .PCSource  (PCSource),
        .IRWrite   (IRWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg)
    );

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: per-cycle expected controls queued, then drained.
module tb_multicycle_main_control;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    logic             clk = 1'b0;
    logic             reset, zero, mem_ready;
    logic [6:0]       opcode;
    logic [1:0]       ALUOp, ALUSrcA, ALUSrcB;
    logic             PCWrite, PCSource, IRWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg;
    logic             illegal_instr, mem_timeout;
    logic [CNT_W-1:0] retired;
    logic [13:0]      act_ctl;

    multicycle_main_control #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCWrite(PCWrite),
        .PCSource(PCSource), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    assign act_ctl = {ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSource, IRWrite,
                      MemRead, MemWrite, IorD, RegWrite, MemtoReg};

    typedef struct {
        logic             rst;
        logic             rdy;
        logic             z;
        logic [6:0]       op;
        logic [13:0]      ctl;
        logic [CNT_W-1:0] ret;
        logic             ill;
        logic             to;
    } cyc_t;

    cyc_t             q[$];
    string            tagq[$];
    int               nchecks = 0;
    int               nerrors = 0;
    logic [6:0]       cur_op = 7'd0;
    logic [CNT_W-1:0] model_ret = '0;
    logic             model_ill = 1'b0;
    logic             model_to = 1'b0;

    function automatic logic [13:0] ctl(input logic [1:0] aop, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic pcw, input logic pcs,
                                        input logic irw, input logic mr, input logic mw,
                                        input logic iord, input logic rw, input logic m2r);
        return {aop, sa, sb, pcw, pcs, irw, mr, mw, iord, rw, m2r};
    endfunction

    task automatic push(input logic r, input logic rdy, input logic z, input logic [13:0] c,
                        input string tag);
        cyc_t e;
        e.rst = r; e.rdy = rdy; e.z = z; e.op = cur_op; e.ctl = c;
        e.ret = model_ret; e.ill = model_ill; e.to = model_to;
        q.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic push_fetch(input int nw);
        for (int i = 0; i < nw; i++)
            push(0, 0, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0), "fetch_wait");
        push(0, 1, 0, ctl(2'b00, 2'b00, 2'b01, 1, 0, 1, 1, 0, 0, 0, 0), "fetch");
    endtask

    task automatic push_decode();
        // mem_ready high here must be ignored
        push(0, 1, 0, ctl(2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
    endtask

    task automatic push_memadr();
        push(0, 0, 0, ctl(2'b00, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0), "memadr");
    endtask

    task automatic push_memrd(input int nw);
        for (int i = 0; i < nw; i++)
            push(0, 0, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0), "memrd_wait");
        push(0, 1, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0), "memrd");
    endtask

    task automatic push_memwb();
        push(0, 0, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1), "memwb");
        model_ret = model_ret + 1'b1;
    endtask

    task automatic push_memwr(input int nw);
        for (int i = 0; i < nw; i++)
            push(0, 0, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0), "memwr_wait");
        push(0, 1, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0), "memwr");
        model_ret = model_ret + 1'b1;
    endtask

    task automatic push_rtype(input int nw);
        cur_op = T_R;
        push_fetch(nw);
        push_decode();
        push(0, 0, 0, ctl(2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "exec_r");
        push(0, 0, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0), "aluwb");
        model_ret = model_ret + 1'b1;
    endtask

    task automatic push_lw(input int fw, input int mw);
        cur_op = T_LOAD;
        push_fetch(fw); push_decode(); push_memadr(); push_memrd(mw); push_memwb();
    endtask

    task automatic push_sw(input int fw, input int mw);
        cur_op = T_STORE;
        push_fetch(fw); push_decode(); push_memadr(); push_memwr(mw);
    endtask

    task automatic push_beq(input logic z);
        cur_op = T_BRANCH;
        push_fetch(0);
        push_decode();
        push(0, 0, z, ctl(2'b01, 2'b01, 2'b00, z, 1, 0, 0, 0, 0, 0, 0), "branch");
        model_ret = model_ret + 1'b1;
    endtask

    task automatic test_reset();
        cyc_t  c;
        string t;
        push(1, 0, 0, 14'd0, "reset_idle");
        push(1, 0, 0, 14'd0, "reset_idle");
        cur_op = T_LOAD;
        push_fetch(0); push_decode(); push_memadr();
        push(0, 0, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0), "memrd_wait");
        push(0, 0, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0), "memrd_wait");
        // reset lands mid-MEMRD with memory ready: no enables, aborted access
        push(1, 1, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0), "reset_memrd");
        push(1, 0, 0, 14'd0, "reset_held");
        push(1, 0, 0, 14'd0, "reset_held");
        push_fetch(1); push_decode(); push_memadr(); push_memrd(0); push_memwb();
        while (q.size() > 0) begin
            c = q.pop_front(); t = tagq.pop_front();
            @(negedge clk);
            reset = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.op;
            #1;
            nchecks++;
            if ({act_ctl, retired, illegal_instr, mem_timeout} !== {c.ctl, c.ret, c.ill, c.to}) begin
                nerrors++;
                $display("FAIL reset/%s: got ctl=%b ret=%0d ill=%b to=%b, expected ctl=%b ret=%0d ill=%b to=%b",
                         t, act_ctl, retired, illegal_instr, mem_timeout, c.ctl, c.ret, c.ill, c.to);
            end
        end
    endtask

    task automatic test_rtype();
        cyc_t  c;
        string t;
        push_rtype(0);
        while (q.size() > 0) begin
            c = q.pop_front(); t = tagq.pop_front();
            @(negedge clk);
            reset = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.op;
            #1;
            nchecks++;
            if ({act_ctl, retired, illegal_instr, mem_timeout} !== {c.ctl, c.ret, c.ill, c.to}) begin
                nerrors++;
                $display("FAIL rtype/%s: got ctl=%b ret=%0d ill=%b to=%b, expected ctl=%b ret=%0d ill=%b to=%b",
                         t, act_ctl, retired, illegal_instr, mem_timeout, c.ctl, c.ret, c.ill, c.to);
            end
        end
    endtask

    task automatic test_lw_wait();
        cyc_t  c;
        string t;
        push_lw(0, 2);
        while (q.size() > 0) begin
            c = q.pop_front(); t = tagq.pop_front();
            @(negedge clk);
            reset = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.op;
            #1;
            nchecks++;
            if ({act_ctl, retired, illegal_instr, mem_timeout} !== {c.ctl, c.ret, c.ill, c.to}) begin
                nerrors++;
                $display("FAIL lw_wait/%s: got ctl=%b ret=%0d ill=%b to=%b, expected ctl=%b ret=%0d ill=%b to=%b",
                         t, act_ctl, retired, illegal_instr, mem_timeout, c.ctl, c.ret, c.ill, c.to);
            end
        end
    endtask

    task automatic test_beq();
        cyc_t  c;
        string t;
        push_beq(1'b1);
        push_beq(1'b0);
        while (q.size() > 0) begin
            c = q.pop_front(); t = tagq.pop_front();
            @(negedge clk);
            reset = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.op;
            #1;
            nchecks++;
            if ({act_ctl, retired, illegal_instr, mem_timeout} !== {c.ctl, c.ret, c.ill, c.to}) begin
                nerrors++;
                $display("FAIL beq/%s: got ctl=%b ret=%0d ill=%b to=%b, expected ctl=%b ret=%0d ill=%b to=%b",
                         t, act_ctl, retired, illegal_instr, mem_timeout, c.ctl, c.ret, c.ill, c.to);
            end
        end
    endtask

    task automatic test_illegal();
        cyc_t  c;
        string t;
        cur_op = T_BAD;
        push_fetch(0);
        push_decode();
        model_ill = 1'b1;
        push_rtype(0);
        while (q.size() > 0) begin
            c = q.pop_front(); t = tagq.pop_front();
            @(negedge clk);
            reset = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.op;
            #1;
            nchecks++;
            if ({act_ctl, retired, illegal_instr, mem_timeout} !== {c.ctl, c.ret, c.ill, c.to}) begin
                nerrors++;
                $display("FAIL illegal/%s: got ctl=%b ret=%0d ill=%b to=%b, expected ctl=%b ret=%0d ill=%b to=%b",
                         t, act_ctl, retired, illegal_instr, mem_timeout, c.ctl, c.ret, c.ill, c.to);
            end
        end
    endtask

    task automatic test_sw_timeout();
        cyc_t  c;
        string t;
        cur_op = T_STORE;
        push_fetch(0); push_decode(); push_memadr();
        for (int i = 0; i < WAIT_MAX; i++)
            push(0, 0, 0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0), "memwr_stall");
        model_to = 1'b1;
        push_sw(0, WAIT_MAX - 1);
        while (q.size() > 0) begin
            c = q.pop_front(); t = tagq.pop_front();
            @(negedge clk);
            reset = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.op;
            #1;
            nchecks++;
            if ({act_ctl, retired, illegal_instr, mem_timeout} !== {c.ctl, c.ret, c.ill, c.to}) begin
                nerrors++;
                $display("FAIL sw_timeout/%s: got ctl=%b ret=%0d ill=%b to=%b, expected ctl=%b ret=%0d ill=%b to=%b",
                         t, act_ctl, retired, illegal_instr, mem_timeout, c.ctl, c.ret, c.ill, c.to);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t  c;
        string t;
        // enough retirements to wrap the narrow counter
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0:       push_rtype($urandom_range(0, 2));
                1:       push_lw($urandom_range(0, 2), $urandom_range(0, 2));
                2:       push_sw($urandom_range(0, 2), $urandom_range(0, 2));
                default: push_beq(1'($urandom_range(0, 1)));
            endcase
        end
        while (q.size() > 0) begin
            c = q.pop_front(); t = tagq.pop_front();
            @(negedge clk);
            reset = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.op;
            #1;
            nchecks++;
            if ({act_ctl, retired, illegal_instr, mem_timeout} !== {c.ctl, c.ret, c.ill, c.to}) begin
                nerrors++;
                $display("FAIL b2b/%s: got ctl=%b ret=%0d ill=%b to=%b, expected ctl=%b ret=%0d ill=%b to=%b",
                         t, act_ctl, retired, illegal_instr, mem_timeout, c.ctl, c.ret, c.ill, c.to);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_sw_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
